// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control unit: a Moore FSM that steps each instruction through
// fetch, decode, execute, memory and write-back over the shared-memory datapath.
module multicycle_control #(
    parameter int MEM_WAIT = 0,
    parameter int WAIT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] OP_i,
    output logic       PC_Write_o,
    output logic       Branch_o,
    output logic       IR_Write_o,
    output logic       IorD_o,
    output logic       Mem_Read_o,
    output logic       Mem_Write_o,
    output logic [1:0] Mem_to_Reg_o,
    output logic       Reg_Write_o,
    output logic [1:0] ALU_Src_A_o,
    output logic [1:0] ALU_Src_B_o,
    output logic [2:0] ALU_Op_o,
    output logic [1:0] PC_Src_o,
    output logic       Illegal_o,
    output logic [3:0] State_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);

    state_t            state_reg;
    state_t            state_next;
    logic [WAIT_W-1:0] cnt_reg;
    logic              done;
    logic              in_mem_state;

    assign done         = (cnt_reg == WAIT_LAST);
    assign in_mem_state = (state_reg == S_FETCH) || (state_reg == S_MEM_RD) ||
                          (state_reg == S_MEM_WR);
    assign State_o      = state_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            // The counter only measures dwell time, so any transition restarts it.
            if (state_next != state_reg) begin
                cnt_reg <= '0;
            end else if (in_mem_state) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        PC_Write_o   = 1'b0;
        Branch_o     = 1'b0;
        IR_Write_o   = 1'b0;
        IorD_o       = 1'b0;
        Mem_Read_o   = 1'b0;
        Mem_Write_o  = 1'b0;
        Mem_to_Reg_o = 2'b00;
        Reg_Write_o  = 1'b0;
        ALU_Src_A_o  = 2'b00;
        ALU_Src_B_o  = 2'b00;
        ALU_Op_o     = 3'b000;
        PC_Src_o     = 2'b00;
        Illegal_o    = 1'b0;

        case (state_reg)
            S_FETCH: begin
                Mem_Read_o  = 1'b1;
                ALU_Src_B_o = 2'b01;
                ALU_Op_o    = 3'b101;
                if (done) begin
                    IR_Write_o = 1'b1;
                    PC_Write_o = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // OldPC + imm lands in ALUOut, ready for BRANCH/JAL.
                ALU_Src_A_o = 2'b10;
                ALU_Src_B_o = 2'b10;
                ALU_Op_o    = 3'b101;
                case (OP_i)
                    OP_R:              state_next = S_EXEC_R;
                    OP_I:              state_next = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADDR;
                    OP_BR:             state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                ALU_Src_A_o = 2'b01;
                state_next  = S_ALU_WB;
            end
            S_EXEC_I: begin
                ALU_Src_A_o = 2'b01;
                ALU_Src_B_o = 2'b10;
                ALU_Op_o    = 3'b001;
                state_next  = S_ALU_WB;
            end
            S_LUI: begin
                ALU_Src_B_o = 2'b10;
                ALU_Op_o    = 3'b010;
                state_next  = S_ALU_WB;
            end
            S_AUIPC: begin
                ALU_Src_A_o = 2'b10;
                ALU_Src_B_o = 2'b10;
                ALU_Op_o    = 3'b101;
                state_next  = S_ALU_WB;
            end
            S_ALU_WB: begin
                Reg_Write_o = 1'b1;
                state_next  = S_FETCH;
            end
            S_MEM_ADDR: begin
                ALU_Src_A_o = 2'b01;
                ALU_Src_B_o = 2'b10;
                ALU_Op_o    = 3'b101;
                if (OP_i == OP_LOAD) begin
                    state_next = S_MEM_RD;
                end else if (OP_i == OP_STORE) begin
                    state_next = S_MEM_WR;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_MEM_RD: begin
                Mem_Read_o = 1'b1;
                IorD_o     = 1'b1;
                if (done) state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = 2'b01;
                state_next   = S_FETCH;
            end
            S_MEM_WR: begin
                IorD_o      = 1'b1;
                Mem_Write_o = 1'b1;
                if (done) state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALU_Src_A_o = 2'b01;
                ALU_Op_o    = 3'b100;
                Branch_o    = 1'b1;
                PC_Src_o    = 2'b01;
                state_next  = S_FETCH;
            end
            S_JAL: begin
                PC_Write_o   = 1'b1;
                PC_Src_o     = 2'b01;
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = 2'b10;
                state_next   = S_FETCH;
            end
            S_JALR: begin
                ALU_Src_A_o  = 2'b01;
                ALU_Src_B_o  = 2'b10;
                ALU_Op_o     = 3'b101;
                PC_Write_o   = 1'b1;
                PC_Src_o     = 2'b10;
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = 2'b10;
                state_next   = S_FETCH;
            end
            S_TRAP: begin
                Illegal_o  = 1'b1;
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: four controller instances with MEM_WAIT = 0..3, driven from a
// table of {instance, reset, opcode, expected outputs} rows plus reset corner cases.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
        logic [3:0] state;
    } outs_t;

    typedef struct {
        int         inst;
        logic       rst;
        logic [6:0] opv;
        outs_t      exp;
    } vec_t;

    //                         pcw   br    irw   iord  mrd   mwr   m2r    rw    A      B      op      pcs    ill   state
    localparam outs_t O_FETCH_W = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 3'b101, 2'b00, 1'b0, 4'd0};
    localparam outs_t O_FETCH_D = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 3'b101, 2'b00, 1'b0, 4'd0};
    localparam outs_t O_DECODE  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 2'b10, 3'b101, 2'b00, 1'b0, 4'd1};
    localparam outs_t O_EXEC_R  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 3'b000, 2'b00, 1'b0, 4'd2};
    localparam outs_t O_EXEC_I  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b10, 3'b001, 2'b00, 1'b0, 4'd3};
    localparam outs_t O_ALU_WB  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 4'd4};
    localparam outs_t O_MEM_AD  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b10, 3'b101, 2'b00, 1'b0, 4'd5};
    localparam outs_t O_MEM_RD  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 4'd6};
    localparam outs_t O_MEM_WB  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 4'd7};
    localparam outs_t O_MEM_WR  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0, 4'd8};
    localparam outs_t O_BRANCH  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, 3'b100, 2'b01, 1'b0, 4'd9};
    localparam outs_t O_JAL     = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0, 4'd10};
    localparam outs_t O_JALR    = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b01, 2'b10, 3'b101, 2'b10, 1'b0, 4'd11};
    localparam outs_t O_LUI     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b10, 3'b010, 2'b00, 1'b0, 4'd12};
    localparam outs_t O_AUIPC   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, 2'b10, 3'b101, 2'b00, 1'b0, 4'd13};
    localparam outs_t O_TRAP    = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1, 4'd15};

    logic       clk = 1'b0;
    logic       rst [4];
    logic [6:0] op  [4];
    outs_t      o   [4];
    int         checks   = 0;
    int         failures = 0;
    bit         started  = 1'b0;
    vec_t       tbl [$];

    always #5 clk = ~clk;

    // Instance gi runs with MEM_WAIT = gi.
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        logic       pcw, br, irw, iord, mrd, mwr, rw, ill;
        logic [1:0] m2r, sa, sb, pcs;
        logic [2:0] aop;
        logic [3:0] st;

        multicycle_control #(.MEM_WAIT(gi), .WAIT_W(4)) u_dut (
            .clk          (clk),
            .reset        (rst[gi]),
            .OP_i         (op[gi]),
            .PC_Write_o   (pcw),
            .Branch_o     (br),
            .IR_Write_o   (irw),
            .IorD_o       (iord),
            .Mem_Read_o   (mrd),
            .Mem_Write_o  (mwr),
            .Mem_to_Reg_o (m2r),
            .Reg_Write_o  (rw),
            .ALU_Src_A_o  (sa),
            .ALU_Src_B_o  (sb),
            .ALU_Op_o     (aop),
            .PC_Src_o     (pcs),
            .Illegal_o    (ill),
            .State_o      (st)
        );

        assign o[gi] = {pcw, br, irw, iord, mrd, mwr, m2r, rw, sa, sb, aop, pcs, ill, st};
    end

    // Strobe exclusivity invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (((o[i].pc_write & o[i].ir_write) === 1'b1 && o[i].state != 4'd0) ||
                    ((o[i].reg_write & o[i].mem_write) === 1'b1)) begin
                    failures++;
                    $display("FAIL strobe_excl inst%0d: got outputs %h, required no PCW&IRW outside FETCH and no RW&MW",
                             i, o[i]);
                end
            end
        end
    end

    task automatic push(input int inst, input logic r, input logic [6:0] opv, input outs_t exp);
        vec_t v;
        v.inst = inst; v.rst = r; v.opv = opv; v.exp = exp;
        tbl.push_back(v);
    endtask

    // One cycle: drive inputs, compare the current-state outputs, then clock.
    task automatic step(input int inst, input logic r, input logic [6:0] opv,
                        input outs_t exp, input string name);
        rst[inst] = r;
        op[inst]  = opv;
        #1;
        checks++;
        if (o[inst] !== exp) begin
            failures++;
            $display("FAIL %s inst%0d: got %h (state %0d) required %h (state %0d)",
                     name, inst, o[inst], o[inst].state, exp, exp.state);
        end else begin
            $display("ok %s inst%0d state=%0d rst=%0b op=%h", name, inst, o[inst].state, r, opv);
        end
        @(posedge clk);
        #1;
        rst[inst] = 1'b0;
    endtask

    task automatic pulse_reset(input int inst);
        rst[inst] = 1'b1;
        @(posedge clk);
        #1;
        rst[inst] = 1'b0;
    endtask

    initial begin
        int prev_inst;
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1;
            op[i]  = 7'h00;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;
        started = 1'b1;

        // MEM_WAIT=0: every instruction class, then an illegal opcode held in TRAP.
        push(0, 0, 7'h33, O_FETCH_D); push(0, 0, 7'h33, O_DECODE);
        push(0, 0, 7'h33, O_EXEC_R);  push(0, 0, 7'h33, O_ALU_WB);
        push(0, 0, 7'h13, O_FETCH_D); push(0, 0, 7'h13, O_DECODE);
        push(0, 0, 7'h13, O_EXEC_I);  push(0, 0, 7'h13, O_ALU_WB);
        push(0, 0, 7'h37, O_FETCH_D); push(0, 0, 7'h37, O_DECODE);
        push(0, 0, 7'h37, O_LUI);     push(0, 0, 7'h37, O_ALU_WB);
        push(0, 0, 7'h17, O_FETCH_D); push(0, 0, 7'h17, O_DECODE);
        push(0, 0, 7'h17, O_AUIPC);   push(0, 0, 7'h17, O_ALU_WB);
        push(0, 0, 7'h03, O_FETCH_D); push(0, 0, 7'h03, O_DECODE);
        push(0, 0, 7'h03, O_MEM_AD);  push(0, 0, 7'h03, O_MEM_RD);
        push(0, 0, 7'h03, O_MEM_WB);
        push(0, 0, 7'h23, O_FETCH_D); push(0, 0, 7'h23, O_DECODE);
        push(0, 0, 7'h23, O_MEM_AD);  push(0, 0, 7'h23, O_MEM_WR);
        push(0, 0, 7'h63, O_FETCH_D); push(0, 0, 7'h63, O_DECODE);
        push(0, 0, 7'h63, O_BRANCH);
        push(0, 0, 7'h6F, O_FETCH_D); push(0, 0, 7'h6F, O_DECODE);
        push(0, 0, 7'h6F, O_JAL);
        push(0, 0, 7'h67, O_FETCH_D); push(0, 0, 7'h67, O_DECODE);
        push(0, 0, 7'h67, O_JALR);
        push(0, 0, 7'h7F, O_FETCH_D); push(0, 0, 7'h7F, O_DECODE);
        for (int k = 0; k < 9; k++) push(0, 0, 7'h33, O_TRAP);
        push(0, 1, 7'h33, O_TRAP);
        push(0, 0, 7'h33, O_FETCH_D);

        // MEM_WAIT=2 load: 3-cycle FETCH and MEM_RD, 9 cycles total.
        push(2, 0, 7'h03, O_FETCH_W); push(2, 0, 7'h03, O_FETCH_W);
        push(2, 0, 7'h03, O_FETCH_D); push(2, 0, 7'h03, O_DECODE);
        push(2, 0, 7'h03, O_MEM_AD);  push(2, 0, 7'h03, O_MEM_RD);
        push(2, 0, 7'h03, O_MEM_RD);  push(2, 0, 7'h03, O_MEM_RD);
        push(2, 0, 7'h03, O_MEM_WB);
        push(2, 0, 7'h13, O_FETCH_W); push(2, 0, 7'h13, O_FETCH_W);
        push(2, 0, 7'h13, O_FETCH_D);

        // MEM_WAIT=1 store: MEM_WR holds for 2 cycles.
        push(1, 0, 7'h23, O_FETCH_W); push(1, 0, 7'h23, O_FETCH_D);
        push(1, 0, 7'h23, O_DECODE);  push(1, 0, 7'h23, O_MEM_AD);
        push(1, 0, 7'h23, O_MEM_WR);  push(1, 0, 7'h23, O_MEM_WR);
        push(1, 0, 7'h23, O_FETCH_W); push(1, 0, 7'h23, O_FETCH_D);

        prev_inst = -1;
        foreach (tbl[r]) begin
            if (tbl[r].inst != prev_inst) begin
                pulse_reset(tbl[r].inst);
                prev_inst = tbl[r].inst;
            end
            step(tbl[r].inst, tbl[r].rst, tbl[r].opv, tbl[r].exp, $sformatf("row%0d", r));
        end

        // MEM_WAIT=3: reset on the second MEM_WR cycle; the refetch must wait a full 4 cycles.
        pulse_reset(3);
        for (int k = 0; k < 3; k++) step(3, 0, 7'h23, O_FETCH_W, "mw3_fetch_wait");
        step(3, 0, 7'h23, O_FETCH_D, "mw3_fetch_done");
        step(3, 0, 7'h23, O_DECODE,  "mw3_decode");
        step(3, 0, 7'h23, O_MEM_AD,  "mw3_mem_addr");
        step(3, 0, 7'h23, O_MEM_WR,  "mw3_mem_wr0");
        step(3, 1, 7'h23, O_MEM_WR,  "mw3_mem_wr1_rst");
        for (int k = 0; k < 3; k++) step(3, 0, 7'h23, O_FETCH_W, "mw3_after_rst_wait");
        step(3, 0, 7'h23, O_FETCH_D, "mw3_after_rst_done");

        // MEM_WAIT=0: reset during ALU_WB aborts it with no write strobe after.
        pulse_reset(0);
        step(0, 0, 7'h13, O_FETCH_D, "abort_fetch");
        step(0, 0, 7'h13, O_DECODE,  "abort_decode");
        step(0, 0, 7'h13, O_EXEC_I,  "abort_exec");
        step(0, 1, 7'h13, O_ALU_WB,  "abort_wb_rst");
        step(0, 0, 7'h13, O_FETCH_D, "abort_refetch");

        started = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle control unit for the RISC-V core. It replaces the single-cycle opcode decoder with a Moore FSM that sequences FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK across clock cycles. The number of memory wait states is a parameter. It adds JAL, JALR and AUIPC support and traps on illegal opcodes. The block drives the shared-memory multi-cycle datapath: PC, IR, OldPC, ALUOut and MDR registers.

Parameters:
MEM_WAIT, 0, extra stall cycles per memory access (0..15)
WAIT_W, 4, width of the internal wait counter; must hold MEM_WAIT

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
OP_i  input  7  opcode, IR[6:0]; valid from DECODE onward
PC_Write_o  output  1  unconditional PC load
Branch_o  output  1  conditional PC load; datapath qualifies it with the funct3 compare result
IR_Write_o  output  1  loads IR and OldPC
IorD_o  output  1  memory address select: 0 = PC, 1 = ALUOut
Mem_Read_o  output  1  memory read strobe
Mem_Write_o  output  1  memory write strobe
Mem_to_Reg_o  output  2  write-back source: 00 = ALUOut, 01 = MDR, 10 = PC (link)
Reg_Write_o  output  1  register file write enable
ALU_Src_A_o  output  2  ALU A operand: 00 = PC, 01 = rs1, 10 = OldPC
ALU_Src_B_o  output  2  ALU B operand: 00 = rs2, 01 = constant 4, 10 = immediate
ALU_Op_o  output  3  ALU control: 000 = R funct, 001 = I logic, 010 = U pass-imm, 100 = branch compare, 101 = forced ADD
PC_Src_o  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = ALU result with bit 0 cleared
Illegal_o  output  1  high while in TRAP
State_o  output  4  current state encoding, for debug

Behaviour:
- Moore outputs: all outputs are a function of state, plus the wait counter in memory states only.
- All outputs default to 0 in every state unless listed below.
- Reset: state = FETCH, counter = 0.
- Reset outputs: FETCH outputs with IR_Write_o = PC_Write_o = 0 (while MEM_WAIT > 0).
- Reset mid-instruction aborts that instruction; no write strobes are asserted in the cycle after reset.
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ALU_WB=4, MEM_ADDR=5, MEM_RD=6, MEM_WB=7, MEM_WR=8, BRANCH=9, JAL=10, JALR=11, LUI=12, AUIPC=13, TRAP=15.
- Wait counter: clears on every state change.
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR.
  - The state exits on the cycle the counter equals MEM_WAIT ("done").
- FETCH: Mem_Read=1, IorD=0, A=00, B=01, ALU_Op=101, PC_Src=00.
  - On done: IR_Write=1, PC_Write=1, next state DECODE.
- DECODE: A=10, B=10, ALU_Op=101, which precomputes the branch/JAL target into ALUOut.
  - Next state by OP_i: 33→EXEC_R, 13→EXEC_I, 03/23→MEM_ADDR, 63→BRANCH, 6F→JAL, 67→JALR, 37→LUI, 17→AUIPC, else TRAP.
- EXEC_R: A=01, B=00, ALU_Op=000 → ALU_WB.
- EXEC_I: A=01, B=10, ALU_Op=001 → ALU_WB.
- LUI: B=10, ALU_Op=010 → ALU_WB.
- AUIPC: A=10, B=10, ALU_Op=101 → ALU_WB.
- ALU_WB: Reg_Write=1, Mem_to_Reg=00 → FETCH.
- MEM_ADDR: A=01, B=10, ALU_Op=101 → MEM_RD if OP_i=03, MEM_WR if OP_i=23.
- MEM_RD: Mem_Read=1, IorD=1; on done → MEM_WB.
- MEM_WB: Reg_Write=1, Mem_to_Reg=01 → FETCH.
- MEM_WR: IorD=1, Mem_Write=1 for every cycle in the state; on done → FETCH.
- BRANCH: A=01, B=00, ALU_Op=100, Branch=1, PC_Src=01 → FETCH.
- JAL: PC_Write=1, PC_Src=01, Reg_Write=1, Mem_to_Reg=10 → FETCH.
- JALR: A=01, B=10, ALU_Op=101, PC_Write=1, PC_Src=10, Reg_Write=1, Mem_to_Reg=10 → FETCH.
- TRAP: Illegal_o=1; holds until reset.
- Cycle counts with MEM_WAIT=0:
  - R/I/LUI/AUIPC: 4
  - load: 5
  - store: 4
  - branch/JAL/JALR: 3
- Each FETCH, MEM_RD and MEM_WR adds MEM_WAIT cycles.
- PC_Write and IR_Write are never both asserted outside FETCH.
- Reg_Write and Mem_Write are never asserted together.

Test Plan:
- MEM_WAIT=0, reset then OP_i=33: State_o sequence 0,1,2,4,0. Reg_Write=1 only in state 4. IR_Write/PC_Write=1 in the first FETCH cycle.
- MEM_WAIT=2, OP_i=03: FETCH lasts 3 cycles with IR_Write only on the 3rd. MEM_RD lasts 3 cycles with Mem_Read=1. Then MEM_WB with Mem_to_Reg=01. 9 cycles total.
- OP_i=23, MEM_WAIT=1: MEM_WR holds Mem_Write=1 for 2 cycles, IorD=1, Reg_Write=0 throughout.
- OP_i=63, then 6F, then 67: BRANCH shows Branch=1, PC_Src=01, PC_Write=0. JAL shows PC_Src=01, Mem_to_Reg=10. JALR shows PC_Src=10. Each instruction takes 3 cycles.
- OP_i=7F in DECODE: next state 15 with Illegal_o=1, held for 10 cycles. Assert reset: State_o=0 and Illegal_o=0 on the next edge.
- Assert reset during MEM_WR (MEM_WAIT=3, counter=1): next cycle is FETCH, Mem_Write=0, counter restarts at 0.
